keypad4x4_emu: RTL and testbench
================================

# keypad4x4_emu

Keypad responder that models a physical 4x4 matrix keypad for the scanner, in both simulation and hardware-in-the-loop. The scanner drives column strobes, and this block drives the row lines as a real keypad would. A single press request closes one key contact. The contact goes through a deterministic bounce phase on press, a programmable hold, and a bounce phase on release, then the block signals completion. The block sits between a test sequencer (or bench) and the scanner's `row`/`col` pins.

## Interface
- `BOUNCE_CYCLES`, default 8: length in clocks of each bounce phase (press and release). 0 disables bounce. Range 0..65535.
- `TOGGLE_CYCLES`, default 2: contact toggles every this many clocks while bouncing. Must be ≥1.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `col`  in  4: column strobes from the scanner. Active-low; any number may be low.
- `row`  out  4: row lines to the scanner. Active-low; idle `4'hF`.
- `start`  in  1: press request, sampled on the rising edge of `clk`.
- `key_pos`  in  4: physical key position, sampled with `start`. `[3:2]` is the row index and `[1:0]` is the column index. This is not the hex legend.
- `hold_cycles`  in  16: clocks the contact stays solidly closed, sampled with `start`. A value of 0 is treated as 1.
- `busy`  out  1: a press sequence is in progress.
- `done`  out  1: single-cycle pulse when a sequence completes.

## Operation
- Registers: `state`, `pos_q[3:0]`, `hold_q[15:0]`, `cnt[15:0]`, `contact`.
- States and transitions:
  - IDLE → (`start`) → BOUNCE_IN, or → HOLD directly if `BOUNCE_CYCLES`=0.
  - BOUNCE_IN runs `BOUNCE_CYCLES` clocks, then → HOLD.
  - HOLD runs `hold_q` clocks, then → BOUNCE_OUT, or → IDLE if `BOUNCE_CYCLES`=0.
  - BOUNCE_OUT runs `BOUNCE_CYCLES` clocks, then → IDLE.
- Accepting a request: `start` is accepted only in IDLE. On acceptance, `key_pos` and `hold_cycles` are latched. `start` while `busy`=1 is ignored, with no queueing.
- Contact value, with k the cycle index within the current phase (starting at 0):
  - BOUNCE_IN: contact is closed when (k / `TOGGLE_CYCLES`) is even.
  - HOLD: contact is closed.
  - BOUNCE_OUT: contact is open when (k / `TOGGLE_CYCLES`) is even.
  - IDLE: contact is open.
- Row output is combinational from `col` and registered state: `row[r]` = 0 iff `contact`=1, r = `pos_q[3:2]`, and `col[pos_q[1:0]]`=0. Otherwise `row[r]`=1.
  - The scanner therefore sees the key only while strobing its column.
  - Other keys are never asserted.
- Multiple low columns: the pressed row still asserts if its column is among them.
- `busy` = (state != IDLE). `done` is asserted for one clock on the cycle the FSM enters IDLE from an active state.
- Reset mid-sequence: the next clock returns to IDLE with `contact`=0, `row`=`4'hF`, `busy`=0, and `done`=0. No `done` pulse is issued for the aborted press.
- Counters: a 16-bit down-counter is reloaded on each phase entry. There is no wrap; terminal count is 1.

## Timing
- Reset values: `row`=`4'hF` (independent of `col`), `busy`=0, `done`=0, state IDLE.
- With `start` accepted at edge T and H = max(`hold_cycles`,1), B = `BOUNCE_CYCLES`:
  - Bounce in: clocks T+1 .. T+B.
  - Hold: clocks T+B+1 .. T+B+H.
  - Bounce out: clocks T+B+H+1 .. T+2B+H.
  - Return to IDLE at T+2B+H+1: `done`=1 and `busy`=0 in that same cycle.
- `busy` rises at T+1. Earliest next accepted `start` is at edge T+2B+H+1.
- `row` responds to `col` changes in the same cycle, with no register stage.

## Test plan
- Reset with `col`=`4'h0` → `row`=`4'hF`, `busy`=0, `done`=0. Assert `rst` mid-HOLD → next clock `row`=`4'hF`, `busy`=0, and no `done` pulse.
- B=8, T=2, `key_pos`=`4'b0110`, H=5, `col` held at `4'b1011` → `row[1]` pattern from T+1:
  - closed, closed, open, open, closed, closed, open, open (bounce in);
  - closed ×5 (hold);
  - open, open, closed, closed, open, open, closed, closed (bounce out).
  - Then `done` pulses at T+22 and `busy` falls at T+22.
- Same press with `col`=`4'b1101` → `row` stays `4'hF` throughout, while `busy`/`done` timing is unchanged.
- `start` pulsed again during HOLD with a different `key_pos` → ignored; the original key and timing complete. Exactly one `done` is issued.
- B=0, `hold_cycles`=0 → `row` is low for exactly 1 clock when the column is strobed. `done` at T+2.
- Rotating scanner strobe (`1110`→`1101`→`1011`→`0111`) with `key_pos`=`4'hF` in HOLD → `row`=`4'b0111` only while `col`=`4'b0111`.

Source files
------------

// File: rtl/keypad4x4_emu_if.sv
// keypad4x4_emu_if: press-request handshake between a test sequencer and the keypad emulator.
interface keypad4x4_emu_if;
   logic        start;
   logic [3:0]  key_pos;
   logic [15:0] hold_cycles;
   logic        busy;
   logic        done;
   modport master (output start, key_pos, hold_cycles, input busy, done);
   modport slave  (input start, key_pos, hold_cycles, output busy, done);
endinterface

// File: rtl/keypad4x4_emu.sv
// keypad4x4_emu: emulates one bouncing key contact of a 4x4 matrix keypad on the scanner's row/col pins.
module keypad4x4_emu #(
   parameter int BOUNCE_CYCLES = 8,
   parameter int TOGGLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            col,
   output logic [3:0]            row,
   keypad4x4_emu_if.slave        req
);
   typedef enum logic [1:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;
   localparam logic [15:0] BLEN = 16'(BOUNCE_CYCLES);
   localparam logic [15:0] TLEN = 16'(TOGGLE_CYCLES);
   state_t      state_q, state_d;
   logic [3:0]  pos_q, pos_d;
   logic [15:0] hold_q, hold_d, cnt_q, cnt_d, tog_q, tog_d;
   logic        contact_q, contact_d, done_q, done_d;
   // contact_d always reflects the next cycle's phase position so row tracks the schedule with no lag
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q - 16'd1;
      tog_d     = (tog_q == 16'd1) ? TLEN : tog_q - 16'd1;
      contact_d = (tog_q == 16'd1) ? ~contact_q : contact_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d     = cnt_q;
            tog_d     = TLEN;
            contact_d = req.start;
            if (req.start) begin
               pos_d   = req.key_pos;
               hold_d  = (req.hold_cycles == 16'd0) ? 16'd1 : req.hold_cycles;
               state_d = (BLEN == 16'd0) ? HOLD : BOUNCE_IN;
               cnt_d   = (BLEN == 16'd0) ? hold_d : BLEN;
            end
         end
         BOUNCE_IN: if (cnt_q == 16'd1) begin
            state_d   = HOLD;
            cnt_d     = hold_q;
            contact_d = 1'b1;
         end
         HOLD: begin
            contact_d = 1'b1;
            if (cnt_q == 16'd1) begin
               state_d   = (BLEN == 16'd0) ? IDLE : BOUNCE_OUT;
               cnt_d     = BLEN;
               tog_d     = TLEN;
               contact_d = 1'b0;
               done_d    = (BLEN == 16'd0);
            end
         end
         BOUNCE_OUT: if (cnt_q == 16'd1) begin
            state_d   = IDLE;
            contact_d = 1'b0;
            done_d    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pos_q     <= '0;
         hold_q    <= '0;
         cnt_q     <= '0;
         tog_q     <= '0;
         contact_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         hold_q    <= hold_d;
         cnt_q     <= cnt_d;
         tog_q     <= tog_d;
         contact_q <= contact_d;
         done_q    <= done_d;
      end
   end
   always_comb begin
      row = 4'hF;
      if (contact_q && !col[pos_q[1:0]]) row[pos_q[3:2]] = 1'b0;
   end
   assign req.busy = (state_q != IDLE);
   assign req.done = done_q;
endmodule

// File: tb/tb_keypad4x4_emu.sv
// tb_keypad4x4_emu: directed checks of bounce/hold timing, column gating, start rejection and reset abort.
module tb_keypad4x4_emu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col = 4'h0;
   logic [3:0]  row0, row1;
   int          checks = 0;
   int          passes = 0;
   int          dones;
   logic [20:0] pat;
   keypad4x4_emu_if if0 ();
   keypad4x4_emu_if if1 ();
   keypad4x4_emu #(.BOUNCE_CYCLES(8), .TOGGLE_CYCLES(2)) u0 (.clk(clk), .rst(rst), .col(col), .row(row0), .req(if0.slave));
   keypad4x4_emu #(.BOUNCE_CYCLES(0), .TOGGLE_CYCLES(1)) u1 (.clk(clk), .rst(rst), .col(col), .row(row1), .req(if1.slave));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic press0(input logic [3:0] k, input logic [15:0] h);
      if0.key_pos = k;
      if0.hold_cycles = h;
      if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
   endtask
   initial begin
      if0.start = 1'b0; if0.key_pos = '0; if0.hold_cycles = '0;
      if1.start = 1'b0; if1.key_pos = '0; if1.hold_cycles = '0;
      // closed=1, cycles T+1..T+21: bounce in, hold x5, bounce out
      pat = 21'b11001100_11111_00110011;
      tick(); tick();
      chk("reset_row", 16'(row0), 16'hF);
      chk("reset_busy", 16'(if0.busy), 16'd0);
      chk("reset_done", 16'(if0.done), 16'd0);
      rst = 1'b0;
      tick();
      // main press, column strobed
      col = 4'b1011;
      press0(4'b0110, 16'd5);
      for (int i = 0; i < 21; i++) begin
         chk($sformatf("pat_row_%0d", i), 16'(row0), pat[20-i] ? 16'hD : 16'hF);
         chk($sformatf("pat_busy_%0d", i), 16'(if0.busy), 16'd1);
         chk($sformatf("pat_done_%0d", i), 16'(if0.done), 16'd0);
         if (i == 10) begin
            col = 4'b1101; #1;
            chk("comb_col_off", 16'(row0), 16'hF);
            col = 4'b1011; #1;
            chk("comb_col_on", 16'(row0), 16'hD);
         end
         tick();
      end
      chk("pat_done_T22", 16'(if0.done), 16'd1);
      chk("pat_busy_T22", 16'(if0.busy), 16'd0);
      tick();
      chk("pat_done_T23", 16'(if0.done), 16'd0);
      // same press, column never strobed
      col = 4'b1101;
      press0(4'b0110, 16'd5);
      for (int i = 0; i < 21; i++) begin
         chk($sformatf("nostrobe_row_%0d", i), 16'(row0), 16'hF);
         chk($sformatf("nostrobe_busy_%0d", i), 16'(if0.busy), 16'd1);
         tick();
      end
      chk("nostrobe_done", 16'(if0.done), 16'd1);
      chk("nostrobe_busy_end", 16'(if0.busy), 16'd0);
      tick();
      // second start during HOLD is ignored; two low columns
      col = 4'b1010;
      dones = 0;
      press0(4'b0110, 16'd5);
      for (int i = 0; i < 21; i++) begin
         chk($sformatf("ign_row_%0d", i), 16'(row0), pat[20-i] ? 16'hD : 16'hF);
         if (i == 9) begin
            if0.key_pos = 4'b0000; if0.hold_cycles = 16'd3; if0.start = 1'b1;
         end
         if (i == 10) if0.start = 1'b0;
         tick();
      end
      for (int i = 0; i < 25; i++) begin
         if (if0.done) dones++;
         tick();
      end
      chk("ign_done_count", 16'(dones), 16'd1);
      chk("ign_busy_end", 16'(if0.busy), 16'd0);
      // no bounce, zero hold treated as one
      col = 4'b1101;
      if1.key_pos = 4'b1001; if1.hold_cycles = 16'd0; if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      chk("b0_row_T1", 16'(row1), 16'hB);
      chk("b0_busy_T1", 16'(if1.busy), 16'd1);
      chk("b0_done_T1", 16'(if1.done), 16'd0);
      tick();
      chk("b0_row_T2", 16'(row1), 16'hF);
      chk("b0_done_T2", 16'(if1.done), 16'd1);
      chk("b0_busy_T2", 16'(if1.busy), 16'd0);
      tick();
      chk("b0_done_T3", 16'(if1.done), 16'd0);
      // rotating strobe during HOLD, key at row3/col3
      col = 4'b1110;
      press0(4'hF, 16'd20);
      for (int i = 0; i < 10; i++) tick();
      col = 4'b1110; #1; chk("rot_1110", 16'(row0), 16'hF);
      col = 4'b1101; #1; chk("rot_1101", 16'(row0), 16'hF);
      col = 4'b1011; #1; chk("rot_1011", 16'(row0), 16'hF);
      col = 4'b0111; #1; chk("rot_0111", 16'(row0), 16'h7);
      col = 4'b1110; #1; chk("rot_back", 16'(row0), 16'hF);
      dones = 0;
      for (int i = 0; i < 60 && dones == 0; i++) begin
         if (if0.done) dones++;
         tick();
      end
      chk("rot_done_seen", 16'(dones), 16'd1);
      // reset mid-HOLD aborts without done
      col = 4'b1011;
      press0(4'b0110, 16'd10);
      for (int i = 0; i < 10; i++) tick();
      chk("abort_pre_row", 16'(row0), 16'hD);
      chk("abort_pre_busy", 16'(if0.busy), 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_row", 16'(row0), 16'hF);
      chk("abort_busy", 16'(if0.busy), 16'd0);
      chk("abort_done", 16'(if0.done), 16'd0);
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         if (if0.done) dones++;
         tick();
      end
      chk("abort_no_done", 16'(dones), 16'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
